reset_domain_sequencer: RTL and testbench

//   Sequences reset deassertion/reassertion across N_DOMAINS downstream reset domains.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_req_sync.sv | 24 ++
 rtl/reset_domain_sequencer.sv | 134 +++++++++++++
 tb/tb_reset_domain_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset domain sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RELEASE = 3'd1,
        GAP     = 3'd2,
        RUN     = 3'd3,
        ASSERT  = 3'd4
    } state_t;

    // Counter must hold the largest terminal count of any phase.
    function automatic int cnt_width(input int hold, input int step, input int timeout);
        int m;
        m = hold;
        if (step > m) m = step;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Multi-flop synchronizer for the asynchronous reset request level.
// Latency: DEPTH cycles; no backpressure.
module reset_req_sync #(
    parameter int DEPTH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/reset_domain_sequencer.sv
// Releases downstream reset domains in ascending order gated by acks, reasserts descending.
// Latency: outputs registered; request seen SYNC_DEPTH+1 cycles after io_sw_req rises.
// Backpressure: a missing ack stalls the release until ACK_TIMEOUT, then flags sticky timeout.
module reset_domain_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int SYNC_DEPTH  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_sw_req,
    input  logic [N_DOMAINS-1:0] io_ack,
    output logic [N_DOMAINS-1:0] io_domain_reset,
    output logic                 io_ready,
    output logic                 io_busy,
    output logic                 io_timeout
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT);
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOMAINS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             req_s;

    reset_req_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_req_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_sw_req),
        .q     (req_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= HOLD;
            cnt             <= '0;
            idx             <= '0;
            io_domain_reset <= '1;
            io_ready        <= 1'b0;
            io_busy         <= 1'b1;
            io_timeout      <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (req_s) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state              <= RELEASE;
                        cnt                <= '0;
                        idx                <= '0;
                        io_domain_reset[0] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Bit idx is already released here, so an abort re-sets it first.
                    if (req_s) begin
                        state                <= ASSERT;
                        cnt                  <= '0;
                        io_domain_reset[idx] <= 1'b1;
                    end else if (io_ack[idx] || (cnt == ACK_LAST)) begin
                        if (!io_ack[idx]) io_timeout <= 1'b1;
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state    <= RUN;
                            io_ready <= 1'b1;
                            io_busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (req_s) begin
                        state                <= ASSERT;
                        cnt                  <= '0;
                        io_domain_reset[idx] <= 1'b1;
                    end else if (cnt == STEP_LAST) begin
                        state                       <= RELEASE;
                        cnt                         <= '0;
                        idx                         <= idx + 1'b1;
                        io_domain_reset[idx + 1'b1] <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (req_s) begin
                        state                     <= ASSERT;
                        cnt                       <= '0;
                        idx                       <= LAST_IDX;
                        io_domain_reset[LAST_IDX] <= 1'b1;
                        io_ready                  <= 1'b0;
                        io_busy                   <= 1'b1;
                    end
                end
                ASSERT: begin
                    // Reassertion always runs to completion; the request is not sampled here.
                    if (cnt == STEP_LAST) begin
                        cnt <= '0;
                        if (idx == '0) begin
                            state <= HOLD;
                        end else begin
                            idx                         <= idx - 1'b1;
                            io_domain_reset[idx - 1'b1] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Directed bench: vector table for the nominal release/reassert flow plus hand-written corner sequences.
module tb_reset_domain_sequencer;

    logic       clock;
    logic       reset;
    logic       io_sw_req;
    logic [3:0] io_ack;
    logic [3:0] io_domain_reset;
    logic       io_ready;
    logic       io_busy;
    logic       io_timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic       req;
        logic [3:0] ack;
        logic [3:0] rst;
        logic       rdy;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vec[22];

    reset_domain_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .io_sw_req       (io_sw_req),
        .io_ack          (io_ack),
        .io_domain_reset (io_domain_reset),
        .io_ready        (io_ready),
        .io_busy         (io_busy),
        .io_timeout      (io_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        io_sw_req = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step_to(vec[i].cyc);
            chk($sformatf("vec%0d.rst", i), 32'(io_domain_reset), 32'(vec[i].rst));
            chk($sformatf("vec%0d.ready", i), 32'(io_ready), 32'(vec[i].rdy));
            chk($sformatf("vec%0d.busy", i), 32'(io_busy), 32'(vec[i].busy));
            chk($sformatf("vec%0d.timeout", i), 32'(io_timeout), 32'(vec[i].to));
            io_sw_req = vec[i].req;
            io_ack    = vec[i].ack;
        end
    endtask

    function automatic logic is_thermo(input logic [3:0] r);
        logic [3:0] x;
        x = ~r;
        return ((x & (x + 4'd1)) == 4'd0);
    endfunction

    initial begin
        int bad;
        // Nominal release with all acks, then a 10-cycle request pulse at cycle 40 and full replay.
        vec[0]  = '{0,  1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[1]  = '{15, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{16, 1'b0, 4'hF, 4'hE, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{20, 1'b0, 4'hF, 4'hE, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{21, 1'b0, 4'hF, 4'hC, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{26, 1'b0, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{31, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{32, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{40, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
        vec[9]  = '{43, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
        vec[10] = '{44, 1'b1, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0};
        vec[11] = '{47, 1'b1, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0};
        vec[12] = '{48, 1'b1, 4'hF, 4'hC, 1'b0, 1'b1, 1'b0};
        vec[13] = '{50, 1'b0, 4'hF, 4'hC, 1'b0, 1'b1, 1'b0};
        vec[14] = '{52, 1'b0, 4'hF, 4'hE, 1'b0, 1'b1, 1'b0};
        vec[15] = '{56, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[16] = '{59, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[17] = '{60, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[18] = '{75, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
        vec[19] = '{76, 1'b0, 4'hF, 4'hE, 1'b0, 1'b1, 1'b0};
        vec[20] = '{91, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
        vec[21] = '{92, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};

        reset     = 1'b1;
        io_sw_req = 1'b0;
        io_ack    = 4'hF;
        do_reset();
        run_vec(0, 21);

        // ack[1] stuck low: timeout 255 cycles after bit1 release, sequence continues.
        io_ack = 4'b1101;
        do_reset();
        step_to(21);
        chk("t3.rst21", 32'(io_domain_reset), 32'hC);
        step_to(275);
        chk("t3.to275", 32'(io_timeout), 32'h0);
        step_to(276);
        chk("t3.to276", 32'(io_timeout), 32'h1);
        chk("t3.rst276", 32'(io_domain_reset), 32'hC);
        step_to(280);
        chk("t3.rst280", 32'(io_domain_reset), 32'h8);
        step_to(286);
        chk("t3.rst286", 32'(io_domain_reset), 32'h0);
        chk("t3.ready", 32'(io_ready), 32'h1);
        step_to(290);
        chk("t3.sticky", 32'(io_timeout), 32'h1);

        // ack[1] arrives exactly on the timeout cycle: ack wins.
        io_ack = 4'b1101;
        do_reset();
        step_to(275);
        io_ack = 4'hF;
        step_to(276);
        chk("t4.to276", 32'(io_timeout), 32'h0);
        step_to(280);
        chk("t4.rst280", 32'(io_domain_reset), 32'h8);
        step_to(286);
        chk("t4.ready", 32'(io_ready), 32'h1);
        chk("t4.to286", 32'(io_timeout), 32'h0);

        // Request while waiting on the idx=2 ack: descending re-assert, bit3 untouched.
        io_ack = 4'b1011;
        do_reset();
        step_to(26);
        chk("t5.rst26", 32'(io_domain_reset), 32'h8);
        step_to(30);
        io_sw_req = 1'b1;
        bad = 0;
        while (cyc < 46) begin
            step();
            if (cyc == 33) chk("t5.rst33", 32'(io_domain_reset), 32'h8);
            if (cyc == 34) chk("t5.rst34", 32'(io_domain_reset), 32'hC);
            if (cyc == 37) chk("t5.rst37", 32'(io_domain_reset), 32'hC);
            if (cyc == 38) chk("t5.rst38", 32'(io_domain_reset), 32'hE);
            if (cyc == 40) io_sw_req = 1'b0;
            if (cyc == 42) chk("t5.rst42", 32'(io_domain_reset), 32'hF);
            if (!io_domain_reset[3] || !is_thermo(io_domain_reset)) bad++;
        end
        chk("t5.bit3_thermo", 32'(bad), 32'h0);
        chk("t5.busy46", 32'(io_busy), 32'h1);
        chk("t5.to46", 32'(io_timeout), 32'h0);
        step_to(61);
        chk("t5.rst61", 32'(io_domain_reset), 32'hF);
        step_to(62);
        chk("t5.rst62", 32'(io_domain_reset), 32'hE);

        // Reset pulsed in GAP after idx=1, then nominal sequence replays.
        io_ack = 4'hF;
        do_reset();
        step_to(23);
        chk("t6.rst23", 32'(io_domain_reset), 32'hC);
        reset = 1'b1;
        step();
        chk("t6.rst_all", 32'(io_domain_reset), 32'hF);
        chk("t6.busy", 32'(io_busy), 32'h1);
        reset = 1'b0;
        cyc   = 0;
        run_vec(0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
